// File: rtl/spi_controller_if.sv
// Command push bus into the SPI controller: one 16-bit frame request per valid/ready handshake.
interface spi_controller_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rw;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_data;

    modport master (output cmd_valid, output cmd_rw, output cmd_addr, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_rw, input cmd_addr, input cmd_data, output cmd_ready);
endinterface

// File: rtl/spi_controller.sv
// SPI mode-0 write-frame master: 4-entry command FIFO feeding a 16-bit MSB-first shifter,
// with programmable sclk half-period and minimum chip-select gap.
module spi_controller #(
    parameter int unsigned HALF_PERIOD = 4,
    parameter int unsigned CS_GAP      = 8,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_controller_if.slave   cmd,
    output logic              sclk,
    output logic              copi,
    output logic              ncs,
    output logic              busy,
    output logic              done
);
    localparam int unsigned FRAME_W = 16;
    localparam int unsigned PTR_W   = 2;
    localparam int unsigned OCC_W   = 3;
    localparam int unsigned PH_W    = 9;
    localparam int unsigned BIT_W   = 5;

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_e;

    state_e               state_q, state_d;
    logic [PH_W-1:0]      ph_q, ph_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [FRAME_W-1:0]   shift_q, shift_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]     count_q, count_d;
    logic                 sclk_q, sclk_d, copi_q, copi_d, ncs_q, ncs_d;
    logic                 busy_q, busy_d, done_q, done_d, ready_q, ready_d;
    logic                 push, pop;
    logic [FRAME_W-1:0]   mem_q [4];

    logic ph_end, hold_end, gap_end;
    assign ph_end   = (ph_q == PH_W'(HALF_PERIOD - 1));
    // HOLD spans a full sclk period so ncs is low for 34 half-periods per frame.
    assign hold_end = (ph_q == PH_W'(2 * HALF_PERIOD - 1));
    assign gap_end  = (ph_q == PH_W'(CS_GAP - 1));

    assign push = cmd.cmd_valid && ready_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {cmd.cmd_rw, cmd.cmd_addr, cmd.cmd_data};
    end

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ph_q     <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sclk_q   <= 1'b0;
            copi_q   <= 1'b0;
            ncs_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            sclk_q   <= sclk_d;
            copi_q   <= copi_d;
            ncs_q    <= ncs_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q + PH_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        sclk_d  = sclk_q;
        copi_d  = copi_q;
        ncs_d   = ncs_q;
        done_d  = 1'b0;
        pop     = 1'b0;

        unique case (state_q)
            IDLE: begin
                ph_d = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = SETUP;
                    shift_d = mem_q[rd_ptr_q];
                    copi_d  = mem_q[rd_ptr_q][FRAME_W-1];
                    ncs_d   = 1'b0;
                    sclk_d  = 1'b0;
                    bit_d   = '0;
                end
            end
            SETUP, LOW: begin
                if (ph_end) begin
                    state_d = HIGH;
                    sclk_d  = 1'b1;
                    bit_d   = bit_q + BIT_W'(1);
                    ph_d    = '0;
                end
            end
            HIGH: begin
                if (ph_end) begin
                    sclk_d = 1'b0;
                    ph_d   = '0;
                    if (bit_q == BIT_W'(FRAME_W)) begin
                        state_d = HOLD;
                    end else begin
                        state_d = LOW;
                        shift_d = {shift_q[FRAME_W-2:0], 1'b0};
                        copi_d  = shift_q[FRAME_W-2];
                    end
                end
            end
            HOLD: begin
                if (hold_end) begin
                    state_d = GAP;
                    ncs_d   = 1'b1;
                    copi_d  = 1'b0;
                    done_d  = 1'b1;
                    ph_d    = '0;
                end
            end
            GAP: begin
                if (gap_end) begin
                    state_d = IDLE;
                    ph_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
                ph_d    = '0;
            end
        endcase

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + OCC_W'(push) - OCC_W'(pop);
        ready_d  = (count_d != OCC_W'(FIFO_DEPTH));
        busy_d   = (count_d != '0) || (state_d != IDLE);
    end

    assign cmd.cmd_ready = ready_q;
    assign sclk = sclk_q;
    assign copi = copi_q;
    assign ncs  = ncs_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule
